// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode trap CSR block: CSR addresses,
// mstatus bit positions, mtvec mode encodings and the redirect FSM states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAP   = 2'd1,
        ST_RET    = 2'd2,
        ST_SETTLE = 2'd3
    } trap_state_e;

    // Machine-only core: MPP is hardwired to M-mode (2'b11).
    function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
        logic [31:0] v;
        v = '0;
        v[MSTATUS_MIE]          = mie;
        v[MSTATUS_MPIE]         = mpie;
        v[MSTATUS_MPP_LO +: 2]  = 2'b11;
        return v;
    endfunction

    function automatic logic [1:0] mtvec_mode_warl(input logic [1:0] mode);
        return (mode == MTVEC_MODE_VECTORED) ? MTVEC_MODE_VECTORED : MTVEC_MODE_DIRECT;
    endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// CSR storage, WARL masking and combinational read mux for trap_csr.
// Optional mscratch register is built when TRAP_CSR_MSCRATCH_EN is defined.
module trap_csr_regs
    import csr_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [11:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        trap_commit,
    input  logic        ret_commit,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_code,
    output logic        mie,
    output logic [31:0] mepc,
    output logic [31:0] mtvec
);

    logic        mie_q;
    logic        mpie_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtvec_q;

    // Trap/MRET commit overrides a same-edge software write to mstatus.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (trap_commit) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (ret_commit) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en && wr_addr == CSR_MSTATUS) begin
            mie_q  <= wr_data[MSTATUS_MIE];
            mpie_q <= wr_data[MSTATUS_MPIE];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (trap_commit) begin
            mepc_q   <= trap_pc & ~32'h3;
            mcause_q <= trap_code;
        end else if (wr_en) begin
            if (wr_addr == CSR_MEPC)   mepc_q   <= wr_data & ~32'h3;
            if (wr_addr == CSR_MCAUSE) mcause_q <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mtvec_q <= '0;
        end else if (wr_en && wr_addr == CSR_MTVEC) begin
            mtvec_q <= {wr_data[31:2], mtvec_mode_warl(wr_data[1:0])};
        end
    end

`ifdef TRAP_CSR_MSCRATCH_EN
    logic [31:0] mscratch_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mscratch_q <= '0;
        end else if (wr_en && wr_addr == CSR_MSCRATCH) begin
            mscratch_q <= wr_data;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CSR_MSTATUS:  rd_data = mstatus_view(mie_q, mpie_q);
            CSR_MTVEC:    rd_data = mtvec_q;
            CSR_MEPC:     rd_data = mepc_q;
            CSR_MCAUSE:   rd_data = mcause_q;
`ifdef TRAP_CSR_MSCRATCH_EN
            CSR_MSCRATCH: rd_data = mscratch_q;
`endif
            default:      rd_data = '0;
        endcase
    end

    assign mie   = mie_q;
    assign mepc  = mepc_q;
    assign mtvec = mtvec_q;

endmodule

// File: rtl/trap_csr.sv
// Machine-mode trap CSR and redirect unit: commits trap reports / MRET and issues
// a one-cycle flush+jump. Optional mscratch via TRAP_CSR_MSCRATCH_EN.
module trap_csr
    import csr_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_WAIT,
    input  logic        TRAP_EN,
    input  logic [31:0] TRAP_PC,
    input  logic [31:0] TRAP_CODE,
    input  logic [31:0] TRAP_JMP_TO,
    input  logic        MRET_EN,
    input  logic [11:0] CSR_RD_ADDR,
    output logic [31:0] CSR_RD_DATA,
    input  logic        CSR_WR_EN,
    input  logic [11:0] CSR_WR_ADDR,
    input  logic [31:0] CSR_WR_DATA,
    output logic        INT_ALLOW,
    output logic [1:0]  TRAP_VEC_MODE,
    output logic [31:0] TRAP_VEC_BASE,
    output logic        FLUSH,
    output logic        JMP_EN,
    output logic [31:0] JMP_PC
);

    trap_state_e state_q, state_d;
    logic        trap_take, ret_take;
    logic        flush_q, flush_d;
    logic [31:0] jmp_pc_q, jmp_pc_d;
    logic        mie;
    logic [31:0] mepc;
    logic [31:0] mtvec;

    trap_csr_regs u_regs (
        .CLK         (CLK),
        .RST         (RST),
        .wr_en       (CSR_WR_EN),
        .wr_addr     (CSR_WR_ADDR),
        .wr_data     (CSR_WR_DATA),
        .rd_addr     (CSR_RD_ADDR),
        .rd_data     (CSR_RD_DATA),
        .trap_commit (trap_take),
        .ret_commit  (ret_take),
        .trap_pc     (TRAP_PC),
        .trap_code   (TRAP_CODE),
        .mie         (mie),
        .mepc        (mepc),
        .mtvec       (mtvec)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            flush_q  <= 1'b0;
            jmp_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            jmp_pc_q <= jmp_pc_d;
        end
    end

    // Requests are only accepted in IDLE; a trap always beats a same-cycle MRET.
    always_comb begin
        state_d   = state_q;
        trap_take = 1'b0;
        ret_take  = 1'b0;
        flush_d   = 1'b0;
        jmp_pc_d  = jmp_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (!MEM_WAIT && TRAP_EN) begin
                    trap_take = 1'b1;
                    flush_d   = 1'b1;
                    jmp_pc_d  = TRAP_JMP_TO;
                    state_d   = ST_TRAP;
                end else if (!MEM_WAIT && MRET_EN) begin
                    ret_take  = 1'b1;
                    flush_d   = 1'b1;
                    jmp_pc_d  = mepc;
                    state_d   = ST_RET;
                end
            end
            ST_TRAP:   state_d = ST_SETTLE;
            ST_RET:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign FLUSH         = flush_q;
    assign JMP_EN        = flush_q;
    assign JMP_PC        = jmp_pc_q;
    assign INT_ALLOW     = mie && (state_q == ST_IDLE);
    assign TRAP_VEC_MODE = mtvec[1:0];
    assign TRAP_VEC_BASE = {mtvec[31:2], 2'b00};

endmodule

// File: tb/tb_trap_csr.sv
// Self-checking bench for trap_csr: direct CSR checks plus a jump-target scoreboard.
module tb_trap_csr;

    logic        CLK;
    logic        RST;
    logic        MEM_WAIT;
    logic        TRAP_EN;
    logic [31:0] TRAP_PC;
    logic [31:0] TRAP_CODE;
    logic [31:0] TRAP_JMP_TO;
    logic        MRET_EN;
    logic [11:0] CSR_RD_ADDR;
    logic [31:0] CSR_RD_DATA;
    logic        CSR_WR_EN;
    logic [11:0] CSR_WR_ADDR;
    logic [31:0] CSR_WR_DATA;
    logic        INT_ALLOW;
    logic [1:0]  TRAP_VEC_MODE;
    logic [31:0] TRAP_VEC_BASE;
    logic        FLUSH;
    logic        JMP_EN;
    logic [31:0] JMP_PC;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    int          pulse_cnt;

    trap_csr dut (
        .CLK           (CLK),
        .RST           (RST),
        .MEM_WAIT      (MEM_WAIT),
        .TRAP_EN       (TRAP_EN),
        .TRAP_PC       (TRAP_PC),
        .TRAP_CODE     (TRAP_CODE),
        .TRAP_JMP_TO   (TRAP_JMP_TO),
        .MRET_EN       (MRET_EN),
        .CSR_RD_ADDR   (CSR_RD_ADDR),
        .CSR_RD_DATA   (CSR_RD_DATA),
        .CSR_WR_EN     (CSR_WR_EN),
        .CSR_WR_ADDR   (CSR_WR_ADDR),
        .CSR_WR_DATA   (CSR_WR_DATA),
        .INT_ALLOW     (INT_ALLOW),
        .TRAP_VEC_MODE (TRAP_VEC_MODE),
        .TRAP_VEC_BASE (TRAP_VEC_BASE),
        .FLUSH         (FLUSH),
        .JMP_EN        (JMP_EN),
        .JMP_PC        (JMP_PC)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every cycle with a flush/jump pulse consumes one expected target.
    always @(negedge CLK) begin
        if (RST && (JMP_EN || FLUSH)) begin
            pulse_cnt++;
            check("flush_eq_jmp", {31'b0, FLUSH}, {31'b0, JMP_EN});
            if (exp_q.size() == 0)
                check("unexpected_jmp", JMP_PC, 32'hFFFF_FFFF ^ JMP_PC);
            else
                check("jmp_pc", JMP_PC, exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
        CSR_WR_EN   = 1'b1;
        CSR_WR_ADDR = addr;
        CSR_WR_DATA = data;
        tick();
        CSR_WR_EN   = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] addr, output logic [31:0] data);
        CSR_RD_ADDR = addr;
        #1;
        data = CSR_RD_DATA;
    endtask

    task automatic set_trap(input logic [31:0] pc, input logic [31:0] code, input logic [31:0] to);
        TRAP_EN     = 1'b1;
        TRAP_PC     = pc;
        TRAP_CODE   = code;
        TRAP_JMP_TO = to;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        csr_rd(addr, d);
        check(tag, d, exp);
    endtask

    initial begin
        int p0;
        n_checks = 0; n_fail = 0; pulse_cnt = 0;
        RST = 1'b0; MEM_WAIT = 1'b0; TRAP_EN = 1'b0; MRET_EN = 1'b0;
        TRAP_PC = '0; TRAP_CODE = '0; TRAP_JMP_TO = '0;
        CSR_RD_ADDR = '0; CSR_WR_EN = 1'b0; CSR_WR_ADDR = '0; CSR_WR_DATA = '0;
        repeat (3) tick();

        // Reset state
        check("rst_flush", {31'b0, FLUSH}, 32'd0);
        check("rst_jmp_en", {31'b0, JMP_EN}, 32'd0);
        check("rst_jmp_pc", JMP_PC, 32'd0);
        check("rst_int_allow", {31'b0, INT_ALLOW}, 32'd0);
        rd_check("rst_mstatus", 12'h300, 32'h0000_1800);
        rd_check("rst_mepc", 12'h341, 32'd0);
        rd_check("rst_mtvec", 12'h305, 32'd0);
        RST = 1'b1;
        tick();

        // mtvec and WARL behaviour
        csr_wr(12'h305, 32'h8000_0001);
        check("vec_base", TRAP_VEC_BASE, 32'h8000_0000);
        check("vec_mode", {30'b0, TRAP_VEC_MODE}, 32'd1);
        rd_check("mtvec_rd", 12'h305, 32'h8000_0001);
        csr_wr(12'h305, 32'h8000_0003);
        check("vec_mode_warl", {30'b0, TRAP_VEC_MODE}, 32'd0);
        rd_check("mtvec_warl_rd", 12'h305, 32'h8000_0000);
        csr_wr(12'h341, 32'h0000_0203);
        rd_check("mepc_mask", 12'h341, 32'h0000_0200);
        csr_wr(12'h342, 32'h8000_000B);
        rd_check("mcause_rw", 12'h342, 32'h8000_000B);
        csr_wr(12'h7C0, 32'h1234_5678);
        rd_check("unimpl_rd", 12'h7C0, 32'd0);
        csr_wr(12'h340, 32'hDEAD_BEEF);
`ifdef TRAP_CSR_MSCRATCH_EN
        rd_check("mscratch", 12'h340, 32'hDEAD_BEEF);
`else
        rd_check("mscratch", 12'h340, 32'd0);
`endif

        // Trap entry with MIE=1
        csr_wr(12'h300, 32'h0000_0008);
        rd_check("mstatus_mie", 12'h300, 32'h0000_1808);
        check("int_allow_on", {31'b0, INT_ALLOW}, 32'd1);
        p0 = pulse_cnt;
        set_trap(32'h100, 32'd2, 32'h8000_0000);
        exp_q.push_back(32'h8000_0000);
        tick();
        TRAP_EN = 1'b0;
        check("trap_int_allow", {31'b0, INT_ALLOW}, 32'd0);
        rd_check("trap_mepc", 12'h341, 32'h100);
        rd_check("trap_mcause", 12'h342, 32'd2);
        rd_check("trap_mstatus", 12'h300, 32'h0000_1880);
        tick();
        check("trap_flush_end", {31'b0, FLUSH}, 32'd0);
        tick();
        check("trap_pulses", pulse_cnt - p0, 32'd1);

        // MRET back to mepc
        p0 = pulse_cnt;
        MRET_EN = 1'b1;
        exp_q.push_back(32'h100);
        tick();
        MRET_EN = 1'b0;
        check("mret_int_allow_busy", {31'b0, INT_ALLOW}, 32'd0);
        rd_check("mret_mstatus", 12'h300, 32'h0000_1888);
        tick();
        check("mret_int_allow_settle", {31'b0, INT_ALLOW}, 32'd0);
        tick();
        check("mret_int_allow_idle", {31'b0, INT_ALLOW}, 32'd1);
        check("mret_pulses", pulse_cnt - p0, 32'd1);

        // Trap and MRET together: trap wins
        p0 = pulse_cnt;
        set_trap(32'h300, 32'd5, 32'h0000_4000);
        MRET_EN = 1'b1;
        exp_q.push_back(32'h0000_4000);
        tick();
        TRAP_EN = 1'b0; MRET_EN = 1'b0;
        repeat (3) tick();
        rd_check("both_mepc", 12'h341, 32'h300);
        rd_check("both_mstatus", 12'h300, 32'h0000_1880);
        check("both_pulses", pulse_cnt - p0, 32'd1);

        // MEM_WAIT holds off a trap
        p0 = pulse_cnt;
        MEM_WAIT = 1'b1;
        set_trap(32'h500, 32'd7, 32'h0000_6000);
        repeat (3) tick();
        check("wait_pulses", pulse_cnt - p0, 32'd0);
        rd_check("wait_mepc", 12'h341, 32'h300);
        MEM_WAIT = 1'b0;
        exp_q.push_back(32'h0000_6000);
        tick();
        rd_check("release_mepc", 12'h341, 32'h500);
        // Keep requesting through TRAP and SETTLE: must be dropped
        set_trap(32'h600, 32'd9, 32'h0000_9000);
        tick();
        tick();
        TRAP_EN = 1'b0;
        repeat (2) tick();
        rd_check("settle_mepc", 12'h341, 32'h500);
        check("settle_pulses", pulse_cnt - p0, 32'd1);

        // CSR writes on the commit edge: FSM wins for mepc, mtvec write lands
        p0 = pulse_cnt;
        set_trap(32'h0000_0A00, 32'd3, 32'h0000_A000);
        CSR_WR_EN = 1'b1; CSR_WR_ADDR = 12'h341; CSR_WR_DATA = 32'h0000_0999;
        exp_q.push_back(32'h0000_A000);
        tick();
        TRAP_EN = 1'b0;
        CSR_WR_ADDR = 12'h305; CSR_WR_DATA = 32'h0000_1000;
        tick();
        CSR_WR_EN = 1'b0;
        tick();
        rd_check("commit_mepc", 12'h341, 32'h0000_0A00);
        rd_check("commit_mtvec", 12'h305, 32'h0000_1000);
        // Same-edge mtvec write with trap commit
        set_trap(32'h0000_0B00, 32'd4, 32'h0000_B000);
        CSR_WR_EN = 1'b1; CSR_WR_ADDR = 12'h305; CSR_WR_DATA = 32'h0000_2001;
        exp_q.push_back(32'h0000_B000);
        tick();
        TRAP_EN = 1'b0; CSR_WR_EN = 1'b0;
        check("commit_vec_base", TRAP_VEC_BASE, 32'h0000_2000);
        check("commit_vec_mode", {30'b0, TRAP_VEC_MODE}, 32'd1);
        repeat (2) tick();
        check("commit_pulses", pulse_cnt - p0, 32'd2);

        // Reset during trap
        set_trap(32'h0000_0C00, 32'd6, 32'h0000_C000);
        tick();
        TRAP_EN = 1'b0;
        #1;
        RST = 1'b0;
        #1;
        check("rstmid_flush", {31'b0, FLUSH}, 32'd0);
        check("rstmid_jmp_en", {31'b0, JMP_EN}, 32'd0);
        check("rstmid_jmp_pc", JMP_PC, 32'd0);
        rd_check("rstmid_mepc", 12'h341, 32'd0);
        tick();
        RST = 1'b1;
        tick();

        // Must be back in IDLE: a fresh trap is taken immediately
        p0 = pulse_cnt;
        set_trap(32'h0000_0700, 32'd1, 32'h0000_7000);
        exp_q.push_back(32'h0000_7000);
        tick();
        TRAP_EN = 1'b0;
        rd_check("post_rst_mepc", 12'h341, 32'h0000_0700);
        repeat (3) tick();
        check("post_rst_pulses", pulse_cnt - p0, 32'd1);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
